// File: rtl/comp_mac.sv
// comp_mac: pipelined multiply-accumulate with signed/unsigned operands.
// Sample path: capture -> (p_stages-1) carry registers -> output/accumulate stage.
// The product is formed at capture time and travels with its valid, mode and
// clear bits. The last stage folds it into the running accumulator.
module comp_mac #(
  parameter int p_size     = 12,
  parameter int p_stages   = 3,
  parameter int p_acc_size = 2*p_size+8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [p_size-1:0]       i_param,
  input  logic [p_size-1:0]       i_param_2,
  input  logic                    i_signed,
  input  logic                    i_acc_clr,
  output logic [2*p_size-1:0]     o_param,
  output logic [p_acc_size-1:0]   o_param_2,
  output logic                    dv,
  output logic                    o_ovf
);

  localparam int pw = 2*p_size;

  logic [pw-1:0]         a_ext;
  logic [pw-1:0]         b_ext;
  logic [pw-1:0]         prod_in;

  // Signals presented to the final (accumulate/output) stage
  logic                  t_vld;
  logic                  t_sgn;
  logic                  t_clr;
  logic [pw-1:0]         t_prod;

  logic [p_acc_size-1:0] prod_ext;
  logic [p_acc_size:0]   sum;
  logic                  ovf_now;

  // Extend operands to product width; low 2*p_size bits of the product of
  // sign-extended operands are the exact two's complement product.
  always_comb begin
    a_ext   = i_signed ? pw'($signed(i_param))   : pw'(i_param);
    b_ext   = i_signed ? pw'($signed(i_param_2)) : pw'(i_param_2);
    prod_in = a_ext * b_ext;
  end

  genvar gi;
  generate
    if (p_stages == 1) begin : g_direct
      assign t_vld  = ena;
      assign t_sgn  = i_signed;
      assign t_clr  = i_acc_clr;
      assign t_prod = prod_in;
    end else begin : g_pipe
      logic          vld_r  [p_stages-1];
      logic          sgn_r  [p_stages-1];
      logic          clr_r  [p_stages-1];
      logic [pw-1:0] prod_r [p_stages-1];

      for (gi = 0; gi < p_stages-1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          // First register: capture the sample, or a bubble when ena is low
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              vld_r[gi]  <= 1'b0;
              sgn_r[gi]  <= 1'b0;
              clr_r[gi]  <= 1'b0;
              prod_r[gi] <= '0;
            end else begin
              vld_r[gi]  <= ena;
              sgn_r[gi]  <= i_signed;
              clr_r[gi]  <= i_acc_clr;
              prod_r[gi] <= prod_in;
            end
          end
        end else begin : g_next
          // Carry register: shift the sample (or bubble) one stage onward
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              vld_r[gi]  <= 1'b0;
              sgn_r[gi]  <= 1'b0;
              clr_r[gi]  <= 1'b0;
              prod_r[gi] <= '0;
            end else begin
              vld_r[gi]  <= vld_r[gi-1];
              sgn_r[gi]  <= sgn_r[gi-1];
              clr_r[gi]  <= clr_r[gi-1];
              prod_r[gi] <= prod_r[gi-1];
            end
          end
        end
      end

      assign t_vld  = vld_r[p_stages-2];
      assign t_sgn  = sgn_r[p_stages-2];
      assign t_clr  = clr_r[p_stages-2];
      assign t_prod = prod_r[p_stages-2];
    end
  endgenerate

  // Accumulator add and overflow detection, using the sample's own mode
  always_comb begin
    prod_ext = t_sgn ? p_acc_size'($signed(t_prod)) : p_acc_size'(t_prod);
    sum      = {1'b0, o_param_2} + {1'b0, prod_ext};
    if (t_sgn)
      ovf_now = (o_param_2[p_acc_size-1] == prod_ext[p_acc_size-1]) &&
                (sum[p_acc_size-1] != o_param_2[p_acc_size-1]);
    else
      ovf_now = sum[p_acc_size];
  end

  // Output stage: on a valid sample publish product and accumulator; hold on bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv        <= 1'b0;
      o_param   <= '0;
      o_param_2 <= '0;
      o_ovf     <= 1'b0;
    end else if (t_vld) begin
      dv      <= 1'b1;
      o_param <= t_prod;
      if (t_clr) begin
        o_param_2 <= prod_ext;
        o_ovf     <= 1'b0;
      end else begin
        o_param_2 <= sum[p_acc_size-1:0];
        o_ovf     <= o_ovf | ovf_now;
      end
    end else begin
      dv <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comp_mac.sv
// Bench for comp_mac: table-driven vectors plus hand-written multi-cycle
// sequences; expectations queue up at drive time and are checked on dv.
module tb_comp_mac;

  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [11:0] i_param = '0;
  logic [11:0] i_param_2 = '0;
  logic        i_signed = 1'b0;
  logic        i_acc_clr = 1'b0;
  logic [23:0] o_param;
  logic [31:0] o_param_2;
  logic        dv;
  logic        o_ovf;

  comp_mac #(.p_size(12), .p_stages(STAGES), .p_acc_size(32)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .i_param(i_param), .i_param_2(i_param_2),
    .i_signed(i_signed), .i_acc_clr(i_acc_clr),
    .o_param(o_param), .o_param_2(o_param_2),
    .dv(dv), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e;
    logic [11:0] a;
    logic [11:0] b;
    logic        s;
    logic        c;
    logic [23:0] ep;
    logic [31:0] eacc;
    logic        eovf;
  } vec_t;

  typedef struct {
    logic [23:0] p;
    logic [31:0] acc;
    logic        ovf;
    int          edge_n;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_it;
  vec_t vecs[11];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  logic [23:0] last_p = '0;
  logic [31:0] last_acc = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [11:0] a, input logic [11:0] b,
                       input logic s, input logic c, input logic [23:0] ep,
                       input logic [31:0] eacc, input logic eovf);
    sb_t it;
    @(negedge clk);
    ena       = e;
    i_param   = a;
    i_param_2 = b;
    i_signed  = s;
    i_acc_clr = c;
    if (e) begin
      it.p      = ep;
      it.acc    = eacc;
      it.ovf    = eovf;
      it.edge_n = edge_cnt + STAGES;
      sb_q.push_back(it);
      $display("drive a=%0d b=%0d signed=%0b clr=%0b -> exp prod=0x%0h acc=0x%0h ovf=%0b",
               a, b, s, c, ep, eacc, eovf);
    end else begin
      $display("drive bubble");
    end
  endtask

  task automatic drain();
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb_q.size(), 0);
  endtask

  // Monitor: compare results on dv, check hold behaviour on idle cycles
  always @(negedge clk) begin
    if (rst) begin
      if (dv) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_dv", 1, 0);
        end else begin
          mon_it = sb_q.pop_front();
          chk("latency_edge", edge_cnt, mon_it.edge_n);
          chk("o_param", o_param, mon_it.p);
          chk("o_param_2", o_param_2, mon_it.acc);
          chk("o_ovf", o_ovf, mon_it.ovf);
          $display("result prod=0x%0h acc=0x%0h ovf=%0b", o_param, o_param_2, o_ovf);
        end
        last_p   = o_param;
        last_acc = o_param_2;
      end else begin
        chk("hold_o_param", o_param, last_p);
        chk("hold_o_param_2", o_param_2, last_acc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;

    vecs[0]  = '{1'b1, 12'd4095, 12'd4095, 1'b0, 1'b1, 24'hFFE001, 32'd16769025, 1'b0};
    vecs[1]  = '{1'b1, 12'h800,  12'd2047, 1'b1, 1'b1, 24'hC00800, 32'hFFC00800, 1'b0};
    vecs[2]  = '{1'b1, 12'd3,    12'd5,    1'b0, 1'b1, 24'd15,     32'd15,       1'b0};
    vecs[3]  = '{1'b1, 12'd2,    12'd7,    1'b0, 1'b0, 24'd14,     32'd29,       1'b0};
    vecs[4]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 24'd0,      32'd0,        1'b0};
    vecs[5]  = '{1'b1, 12'd10,   12'd10,   1'b0, 1'b0, 24'd100,    32'd129,      1'b0};
    vecs[6]  = '{1'b1, 12'd1,    12'd1,    1'b0, 1'b0, 24'd1,      32'd130,      1'b0};
    vecs[7]  = '{1'b1, 12'hFFF,  12'd3,    1'b1, 1'b0, 24'hFFFFFD, 32'd127,      1'b0};
    vecs[8]  = '{1'b1, 12'hFFF,  12'd3,    1'b0, 1'b0, 24'h002FFD, 32'd12412,    1'b0};
    vecs[9]  = '{1'b1, 12'h800,  12'h800,  1'b1, 1'b0, 24'h400000, 32'd4206716,  1'b0};
    vecs[10] = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 24'd0,      32'd0,        1'b0};

    // Reset with random activity on the inputs
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ena       = 1'($urandom);
      i_param   = 12'($urandom);
      i_param_2 = 12'($urandom);
      i_signed  = 1'($urandom);
      i_acc_clr = 1'($urandom);
      if (i >= 5) begin
        chk("rst_o_param", o_param, 0);
        chk("rst_o_param_2", o_param_2, 0);
        chk("rst_dv", dv, 0);
        chk("rst_o_ovf", o_ovf, 0);
      end
    end
    @(negedge clk);
    ena = 1'b0;
    rst = 1'b1;

    // Table vectors, back to back (entry 4 is a bubble)
    for (int i = 0; i < 11; i++)
      drive(vecs[i].e, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
            vecs[i].ep, vecs[i].eacc, vecs[i].eovf);
    drain();

    // Unsigned overflow: 257 samples of 4095*4095, first one clears
    for (int k = 1; k <= 257; k++) begin
      v = longint'(k) * 64'd16769025;
      drive(1'b1, 12'd4095, 12'd4095, 1'b0, (k == 1), 24'hFFE001, v[31:0], (k >= 257));
    end
    drive(1'b1, 12'd1, 12'd1, 1'b0, 1'b1, 24'd1, 32'd1, 1'b0);
    drain();

    // Signed overflow: (-2048)*(-2048) repeatedly, crossing +2^31 at sample 512
    for (int k = 1; k <= 512; k++) begin
      v = longint'(k) * 64'd4194304;
      drive(1'b1, 12'h800, 12'h800, 1'b1, (k == 1), 24'h400000, v[31:0], (k >= 512));
    end
    drive(1'b1, 12'd1, 12'd1, 1'b0, 1'b1, 24'd1, 32'd1, 1'b0);
    drain();

    // Reset mid-pipeline: two samples in flight are discarded
    drive(1'b1, 12'd9, 12'd9, 1'b0, 1'b1, 24'd81, 32'd81, 1'b0);
    drive(1'b1, 12'd4, 12'd4, 1'b0, 1'b0, 24'd16, 32'd97, 1'b0);
    @(negedge clk);
    ena = 1'b0;
    rst = 1'b0;
    sb_q.delete();
    last_p   = '0;
    last_acc = '0;
    $display("reset asserted mid-pipeline");
    @(negedge clk);
    chk("midrst_dv", dv, 0);
    chk("midrst_o_param", o_param, 0);
    chk("midrst_o_param_2", o_param_2, 0);
    chk("midrst_o_ovf", o_ovf, 0);
    rst = 1'b1;
    drive(1'b1, 12'd6, 12'd7, 1'b0, 1'b1, 24'd42, 32'd42, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_mac.md
# comp_mac

Parametrised, pipelined multiply-accumulate component for the datapath compute blocks. It accepts one operand pair per clock under `ena` and supports signed and unsigned operands. The full-precision product emerges after a configurable pipeline latency, qualified by `dv`, together with a running accumulator that can be cleared in-band and has a sticky overflow flag. It sits between operand-producing front-ends and downstream filters or statistics blocks that consume `dv`-qualified results.

## Interface

Parameters:
- `p_size`, 12: operand width in bits (2..32).
- `p_stages`, 3: pipeline latency from `ena` to `dv` in cycles (1..8).
- `p_acc_size`, `2*p_size+8`: accumulator width. Must be ≥ `2*p_size`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  input sample strobe; operands are captured when high.
- `i_param`  in  `p_size`  operand A.
- `i_param_2`  in  `p_size`  operand B.
- `i_signed`  in  1  operand interpretation, sampled with `ena`: 1 = two's complement, 0 = unsigned.
- `i_acc_clr`  in  1  sampled with `ena`: this sample restarts the accumulator.
- `o_param`  out  `2*p_size`  product of the sample currently presented.
- `o_param_2`  out  `p_acc_size`  accumulator value including the current sample.
- `dv`  out  1  one-cycle valid for `o_param` / `o_param_2`.
- `o_ovf`  out  1  sticky accumulator overflow flag.

## Operation

- Capture: on a rising edge with `ena`=1, the block registers `i_param`, `i_param_2`, `i_signed` and `i_acc_clr` into stage 1 with a valid bit. With `ena`=0, a bubble (valid=0) enters instead.
- Multiply: the product is full precision, `2*p_size` bits.
  - Signed mode: both operands are sign-extended. The result is the exact two's complement product.
  - Unsigned mode: both operands are zero-extended.
- Pipeline: there are `p_stages` register stages. The valid bit, `i_signed` and `i_acc_clr` travel alongside the data. Throughput is one sample per cycle, and bubbles are preserved exactly.
- Accumulate: this happens on the final stage, on the edge where valid reaches the output.
  - Product extension: the product is extended to `p_acc_size` bits, sign-extended when the sample's `i_signed`=1 and zero-extended otherwise.
  - Clear sample (`i_acc_clr`=1): acc := product, and `o_ovf` is cleared.
  - Otherwise: acc := acc + product, wrapping modulo 2^`p_acc_size`.
- Overflow: `o_ovf` is set and held until the next clear sample or reset.
  - Unsigned sample: set on carry out of the MSB.
  - Signed sample: set when both addends share a sign and the result's sign differs.
  - If the same sample both clears and would overflow: clear wins, so `o_ovf`=0.
- Output register: on a valid edge, `o_param` and `o_param_2` are updated and `dv`=1. On a bubble edge, `dv`=0 and both data outputs hold their last values.
- Mode mixing: `i_signed` may change per sample. The accumulator treats each product according to its own sample's mode.
- Reset (`rst`=0, asynchronous): all valid bits, `dv`, `o_param`, `o_param_2` and `o_ovf` go to 0 immediately. In-flight samples are discarded and never produce `dv`. Operation resumes on the first edge after `rst` returns to 1.

## Timing

- A sample accepted on edge T produces `dv`=1 during the cycle following edge T+`p_stages`-1, i.e. `p_stages` cycles after the capturing edge.
- The accumulator value that includes the sample appears in the same cycle as its `dv`.
- With N consecutive `ena` cycles, `dv` is high for exactly N consecutive cycles.
- Reset values of all outputs: 0.

## Test plan

Defaults for all scenarios: `p_size`=12, `p_stages`=3, `p_acc_size`=32.

- Reset: hold `rst`=0 with random inputs and toggling `ena`. Required: `o_param`=0, `o_param_2`=0, `dv`=0, `o_ovf`=0.
- Unsigned extreme: A=4095, B=4095, unsigned, clear. Required:
  - `dv` exactly 3 cycles later;
  - `o_param`=0xFFE001;
  - `o_param_2`=16769025.
- Signed extreme: A=-2048 (0x800), B=2047, signed, clear. Required:
  - `o_param`=0xC00800;
  - `o_param_2`=0xFFC00800;
  - `o_ovf`=0.
- Back-to-back with bubble: operand pairs (3,5, clear), (2,7), `ena`=0 for one cycle, (10,10), (1,1). Required:
  - `dv` pattern 1,1,0,1,1;
  - `o_param_2` = 15, 29, (hold 29), 129, 130.
- Overflow: 257 unsigned samples of 4095×4095, the first with clear. Required:
  - `o_ovf`=0 through sample 256 (acc=4292870400);
  - at sample 257, `o_ovf`=1 and acc=14672129;
  - the next clear sample 1×1 gives acc=1 and `o_ovf`=0.
- Reset mid-pipeline: accept 2 samples, then assert `rst` for one cycle one edge later. Required: `dv` never asserts for those samples. A sample 6×7 with clear after release gives `o_param`=42 and `dv` exactly 3 cycles after capture.
